// File: rtl/random_scheduler.sv
// Round-robin scheduler that hands out 4-bit values from a shared 8-bit Fibonacci LFSR,
// advancing the LFSR SPACING steps between consecutive deliveries.
module random_scheduler #(
  parameter int          N_REQ   = 4,
  parameter int          SPACING = 4,
  parameter logic [7:0]  SEED    = 8'h01
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [N_REQ-1:0] req_in,
  output logic [N_REQ-1:0] gnt_out,
  output logic [3:0]       data_out,
  output logic             valid_out,
  input  logic             seed_load_in,
  input  logic [7:0]       seed_in,
  output logic             busy_out,
  output logic [7:0]       lfsr_state_out
);

  localparam int               IDX_W     = $clog2(N_REQ);
  localparam logic [7:0]       SEED_FIX  = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [3:0]       SPACING_V = 4'(SPACING);
  localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0  = N_REQ'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STEP    = 2'd1,
    DELIVER = 2'd2
  } state_t;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // The all-zero state is a lock-up state, so a zero seed is replaced.
  function automatic logic [7:0] seed_fix(input logic [7:0] s);
    return (s == 8'h00) ? 8'h01 : s;
  endfunction

  state_t           state_r, state_s;
  logic [3:0]       cnt_r, cnt_s;
  logic [7:0]       lfsr_r, lfsr_s;
  logic [IDX_W-1:0] winner_r, winner_s;
  logic [IDX_W-1:0] last_winner_r, last_winner_s;
  logic [IDX_W-1:0] pick_s;
  logic             found_s;
  logic [N_REQ-1:0] gnt_r;
  logic             valid_r;
  logic [3:0]       data_r;
  logic             busy_r;

  // Round-robin search starting just after the last winner.
  always_comb begin : rr_pick
    int idx;
    pick_s  = last_winner_r;
    found_s = 1'b0;
    idx     = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = int'(last_winner_r) + i;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end else begin
        idx = idx;
      end
      if (!found_s && req_in[IDX_W'(idx)]) begin
        found_s = 1'b1;
        pick_s  = IDX_W'(idx);
      end else begin
        pick_s  = pick_s;
      end
    end
  end

  // Next-state logic; a seed load overrides whatever the FSM was doing.
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    lfsr_s        = lfsr_r;
    winner_s      = winner_r;
    last_winner_s = last_winner_r;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          winner_s = pick_s;
          cnt_s    = SPACING_V;
          state_s  = STEP;
        end else begin
          state_s  = IDLE;
        end
      end
      STEP: begin
        lfsr_s = lfsr_step(lfsr_r);
        cnt_s  = cnt_r - 4'd1;
        if (cnt_r == 4'd1) begin
          state_s = DELIVER;
        end else begin
          state_s = STEP;
        end
      end
      DELIVER: begin
        last_winner_s = winner_r;
        state_s       = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    if (seed_load_in) begin
      lfsr_s        = seed_fix(seed_in);
      state_s       = IDLE;
      cnt_s         = 4'd0;
      last_winner_s = last_winner_r;
    end else begin
      lfsr_s        = lfsr_s;
    end
  end

  // State and registered outputs; outputs are computed from the next state so they align with DELIVER.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r       <= IDLE;
      cnt_r         <= 4'd0;
      lfsr_r        <= SEED_FIX;
      winner_r      <= LAST_RST;
      last_winner_r <= LAST_RST;
      gnt_r         <= '0;
      valid_r       <= 1'b0;
      data_r        <= 4'd0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      lfsr_r        <= lfsr_s;
      winner_r      <= winner_s;
      last_winner_r <= last_winner_s;
      gnt_r         <= (state_s == DELIVER) ? (ONE_HOT0 << winner_s) : '0;
      valid_r       <= (state_s == DELIVER);
      data_r        <= (state_s == DELIVER) ? lfsr_s[3:0] : data_r;
      busy_r        <= (state_s != IDLE);
    end
  end

  assign gnt_out        = gnt_r;
  assign valid_out      = valid_r;
  assign data_out       = data_r;
  assign busy_out       = busy_r;
  assign lfsr_state_out = lfsr_r;

endmodule

// File: tb/tb_random_scheduler.sv
// Directed bench for random_scheduler: default instance plus a SPACING=1 instance for the period check.
module tb_random_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, req1;
  logic       seed_load, seed_load1;
  logic [7:0] seed, seed1;
  logic [3:0] gnt, gnt1, data, data1;
  logic       valid, valid1, busy, busy1;
  logic [7:0] lfsr, lfsr1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  random_scheduler dut (
    .clk_in(clk), .rst_in(rst), .req_in(req), .gnt_out(gnt), .data_out(data),
    .valid_out(valid), .seed_load_in(seed_load), .seed_in(seed),
    .busy_out(busy), .lfsr_state_out(lfsr)
  );

  random_scheduler #(.N_REQ(4), .SPACING(1), .SEED(8'h01)) dut1 (
    .clk_in(clk), .rst_in(rst), .req_in(req1), .gnt_out(gnt1), .data_out(data1),
    .valid_out(valid1), .seed_load_in(seed_load1), .seed_in(seed1),
    .busy_out(busy1), .lfsr_state_out(lfsr1)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output logic [3:0] g, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!valid && cyc < 40);
    g = valid ? gnt : 4'h0;
  endtask

  logic [7:0] steps_a [4] = '{8'h02, 8'h04, 8'h08, 8'h11};
  logic [3:0] rot_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    logic [3:0] g;
    int cyc, pulses, grants, zeros, early;
    rst = 1'b1; req = 4'h0; req1 = 4'h0;
    seed_load = 1'b0; seed = 8'h00; seed_load1 = 1'b0; seed1 = 8'h00;
    tick(); tick();
    check_value("rst_gnt", gnt, 4'h0);
    check_value("rst_valid", valid, 1'b0);
    check_value("rst_data", data, 4'h0);
    check_value("rst_busy", busy, 1'b0);
    check_value("rst_lfsr", lfsr, 8'h01);
    rst = 1'b0;

    // First delivery to requester 0
    req = 4'b0001;
    tick();
    check_value("step_busy", busy, 1'b1);
    check_value("step_lfsr0", lfsr, 8'h01);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_value($sformatf("step_lfsr%0d", k + 1), lfsr, steps_a[k]);
      check_value($sformatf("step_valid%0d", k + 1), valid, (k == 3) ? 1'b1 : 1'b0);
    end
    check_value("g1_gnt", gnt, 4'b0001);
    check_value("g1_data", data, 4'h1);

    // Second delivery, held request
    wait_grant(g, cyc);
    check_value("g2_gnt", g, 4'b0001);
    check_value("g2_spacing", cyc, 6);
    check_value("g2_lfsr", lfsr, 8'h1C);
    check_value("g2_data", data, 4'hC);

    // Zero seed load during STEP cancels the operation
    tick();
    check_value("idle_valid", valid, 1'b0);
    check_value("idle_data_hold", data, 4'hC);
    tick(); tick();
    check_value("pre_load_lfsr", lfsr, 8'h38);
    seed_load = 1'b1; seed = 8'h00;
    tick();
    seed_load = 1'b0; req = 4'h0;
    check_value("load_lfsr", lfsr, 8'h01);
    check_value("load_busy", busy, 1'b0);
    check_value("load_valid", valid, 1'b0);
    check_value("load_data", data, 4'hC);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (valid || gnt != 4'h0) pulses++;
    end
    check_value("load_no_grant", pulses, 0);
    check_value("idle_lfsr_hold", lfsr, 8'h01);
    seed = 8'hAB; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    check_value("load_ab", lfsr, 8'hAB);

    // Round-robin rotation with all requesters active
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g, cyc);
      check_value($sformatf("rot_gnt%0d", k), g, rot_exp[k]);
      check_value($sformatf("rot_cyc%0d", k), cyc, (k == 0) ? 5 : 6);
    end

    // Reset aborts mid-STEP; requester 0 then has first priority
    rst = 1'b1; req = 4'h0; tick(); rst = 1'b0;
    req = 4'b0100;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    check_value("abort_gnt", gnt, 4'h0);
    check_value("abort_valid", valid, 1'b0);
    check_value("abort_data", data, 4'h0);
    check_value("abort_busy", busy, 1'b0);
    check_value("abort_lfsr", lfsr, 8'h01);
    rst = 1'b0; req = 4'b0101;
    wait_grant(g, cyc);
    check_value("post_rst_gnt0", g, 4'b0001);
    wait_grant(g, cyc);
    check_value("post_rst_gnt2", g, 4'b0100);

    // Committed grant survives request drop
    rst = 1'b1; req = 4'h0; tick(); rst = 1'b0;
    req = 4'b0010;
    tick();
    req = 4'h0;
    wait_grant(g, cyc);
    check_value("commit_gnt", g, 4'b0010);
    check_value("commit_data", data, 4'h1);
    wait_grant(g, cyc);
    check_value("no_req_no_grant", g, 4'h0);

    // LFSR period with SPACING=1
    rst = 1'b1; tick(); rst = 1'b0;
    req1 = 4'b0001;
    grants = 0; zeros = 0; early = 0;
    for (int k = 0; k < 2000 && grants < 255; k++) begin
      tick();
      if (lfsr1 == 8'h00) zeros++;
      if (valid1) begin
        grants++;
        if (grants == 1) begin
          check_value("sp1_first_gnt", gnt1, 4'b0001);
          check_value("sp1_first_data", data1, 4'h2);
        end
        if (grants < 255 && lfsr1 == 8'h01) early++;
      end
    end
    req1 = 4'h0;
    check_value("sp1_grants", grants, 255);
    check_value("sp1_zero_state", zeros, 0);
    check_value("sp1_early_return", early, 0);
    check_value("sp1_period_lfsr", lfsr1, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
